// File: rtl/inc_dec_counter_pkg.sv
// inc_dec_counter_pkg: request code shared by up/down counters ({inc,dec} -> HOLD/DOWN/UP)
package inc_dec_counter_pkg;
  typedef enum logic [1:0] {
    REQ_HOLD = 2'b00,
    REQ_DOWN = 2'b01,
    REQ_UP   = 2'b10,
    REQ_BOTH = 2'b11
  } req_e;
  function automatic req_e req_decode(input logic inc, input logic dec);
    return req_e'({inc, dec});
  endfunction
endpackage

// File: rtl/inc_dec_counter.sv
// inc_dec_counter: WIDTH-bit wrapping up/down counter; clk, rst (sync high), inc, dec in; cnt registered out
module inc_dec_counter
  import inc_dec_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt
);
  logic [WIDTH-1:0] cnt_q = '0;
  logic [WIDTH-1:0] cnt_d;
  req_e             req;
  always_comb begin
    req   = req_decode(inc, dec);
    cnt_d = req == REQ_UP   ? cnt_q + WIDTH'(1) :
            req == REQ_DOWN ? cnt_q - WIDTH'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
`ifndef SYNTHESIS
  a_known: assert property (@(posedge clk) !$isunknown(cnt_q));
  a_both_hold: assert property (@(posedge clk) (inc && dec && !rst) |=> $stable(cnt_q));
`endif
endmodule

// File: tb/tb_inc_dec_counter.sv
// tb_inc_dec_counter: directed vectors with a scoreboard queue checked by an independent monitor
module tb_inc_dec_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic [3:0] cnt;
  int         total = 0;
  int         bad = 0;
  int         step_no = 0;
  logic [3:0] exp_q[$];
  int         tag_q[$];

  inc_dec_counter #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .inc(inc), .dec(dec), .cnt(cnt));

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic i, input logic d, input logic [3:0] e);
    @(negedge clk);
    rst = r;
    inc = i;
    dec = d;
    exp_q.push_back(e);
    tag_q.push_back(step_no);
    step_no++;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [3:0] e;
      int t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (cnt !== e) begin
        bad++;
        $display("FAIL cnt step %0d: got %0d expected %0d", t, cnt, e);
      end
    end
  end

  initial begin
    #1;
    total++;
    if (cnt !== 4'd0) begin
      bad++;
      $display("FAIL power_up: got %0d expected 0", cnt);
    end
    step(1, 1, 0, 4'd0);
    step(0, 0, 0, 4'd0);
    step(0, 0, 0, 4'd0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 1, 0, 4'(k));
      step(0, 0, 0, 4'(k));
    end
    for (int k = 9; k >= 5; k--) begin
      step(0, 0, 1, 4'(k));
      step(0, 0, 0, 4'(k));
    end
    step(0, 1, 0, 4'd6);
    step(0, 0, 0, 4'd6);
    step(0, 1, 0, 4'd7);
    step(0, 1, 1, 4'd7);
    step(0, 0, 0, 4'd7);
    step(0, 0, 0, 4'd7);
    for (int k = 8; k <= 15; k++) step(0, 1, 0, 4'(k));
    step(0, 1, 0, 4'd0);
    step(0, 0, 1, 4'd15);
    step(0, 1, 0, 4'd0);
    for (int k = 1; k <= 20; k++) step(0, 1, 0, 4'(k % 16));
    step(0, 0, 0, 4'd4);
    for (int k = 5; k <= 9; k++) step(0, 1, 0, 4'(k));
    step(1, 0, 1, 4'd0);
    step(0, 1, 0, 4'd1);
    step(0, 0, 0, 4'd1);
    @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
